recip_byte_shim: RTL and testbench

Byte-serial front/back end for the combinational `reciprocal` core. The top level has only 8-bit pins, so this shim assembles the core's 24-bit operand from three byte writes, holds it stable while the core settles, captures the 24-bit result and saturation flag, and streams them back as four byte reads. It sits between the pin-level control logic and the `reciprocal` instance.

---
 rtl/recip_pkg.sv | 17 +
 rtl/recip_byte_mux.sv | 32 +++
 rtl/recip_byte_shim.sv | 136 +++++++++++++
 tb/tb_recip_byte_shim.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/recip_pkg.sv
// Shared types and constants for the byte-serial reciprocal shim.
// State encoding, widths and status-byte bit positions.
package recip_pkg;

    typedef enum logic [1:0] {
        LOAD,
        WAIT,
        READ
    } state_t;

    localparam int RECIP_W       = 24;
    localparam int OPERAND_BYTES = 3;
    localparam int RESULT_BYTES  = 4;
    localparam int STAT_SAT      = 7;
    localparam int STAT_ABS      = 6;

endpackage

// File: rtl/recip_byte_mux.sv
// Read-byte selector: picks a result byte (MSB first) or the status byte.
// Ports: result/sat/abs (captured result), idx (read index), sel (byte).
module recip_byte_mux
    import recip_pkg::*;
#(
    parameter int DATA_W = RECIP_W,
    parameter int IW     = 2
) (
    input  logic [DATA_W-1:0] result,
    input  logic              sat,
    input  logic              abs,
    input  logic [IW-1:0]     idx,
    output logic [7:0]        sel
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] shifted;

    always_comb begin
        shifted = '0;
        sel     = 8'h00;
        if (int'(idx) < NB) begin
            shifted = result >> (8 * (NB - 1 - int'(idx)));
            sel     = shifted[7:0];
        end else begin
            sel[STAT_SAT] = sat;
            sel[STAT_ABS] = abs;
        end
    end

endmodule

// File: rtl/recip_byte_shim.sv
// Byte-serial front/back end for the combinational reciprocal core.
// Ports: clk/reset; i_byte/i_wr/i_abs writes; i_rd/o_byte reads;
// o_ready/o_valid/o_overrun status; o_recip_*/i_recip_* to the core.
module recip_byte_shim
    import recip_pkg::*;
#(
    parameter int DATA_W      = RECIP_W,
    parameter int RESULT_WAIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        i_byte,
    input  logic              i_wr,
    input  logic              i_abs,
    input  logic              i_rd,
    output logic [7:0]        o_byte,
    output logic              o_ready,
    output logic              o_valid,
    output logic              o_overrun,
    output logic [DATA_W-1:0] o_recip_data,
    output logic              o_recip_abs,
    input  logic [DATA_W-1:0] i_recip_data,
    input  logic              i_recip_sat
);

    localparam int NB = DATA_W / 8;
    localparam int IW = $clog2(NB + 1);

    state_t            state_q, state_d;
    logic [IW-1:0]     wr_idx_q, wr_idx_d;
    logic [IW-1:0]     rd_idx_q, rd_idx_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              abs_q, abs_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              sat_q, sat_d;
    logic              ovr_q, ovr_d;
    logic [7:0]        byte_q, byte_d;
    logic [7:0]        mux_byte;

    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        abs_d    = abs_q;
        res_d    = res_q;
        sat_d    = sat_q;
        ovr_d    = ovr_q | (i_wr & (state_q != LOAD));
        unique case (state_q)
            LOAD: begin
                if (i_wr) begin
                    data_d   = {data_q[DATA_W-9:0], i_byte};
                    wr_idx_d = wr_idx_q + 1'b1;
                    if (wr_idx_q == IW'(NB - 1)) begin
                        abs_d    = i_abs;
                        cnt_d    = 4'(RESULT_WAIT - 1);
                        wr_idx_d = '0;
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    res_d    = i_recip_data;
                    sat_d    = i_recip_sat;
                    rd_idx_d = '0;
                    state_d  = READ;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            READ: begin
                if (i_rd) begin
                    if (rd_idx_q == IW'(NB)) begin
                        rd_idx_d = '0;
                        state_d  = LOAD;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // o_byte is registered from the next-state view so the first
    // result byte appears right after the capture edge.
    recip_byte_mux #(
        .DATA_W (DATA_W),
        .IW     (IW)
    ) u_mux (
        .result (res_d),
        .sat    (sat_d),
        .abs    (abs_d),
        .idx    (rd_idx_d),
        .sel    (mux_byte)
    );

    assign byte_d = (state_d == READ) ? mux_byte : 8'h00;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= LOAD;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            abs_q    <= 1'b0;
            res_q    <= '0;
            sat_q    <= 1'b0;
            ovr_q    <= 1'b0;
            byte_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            abs_q    <= abs_d;
            res_q    <= res_d;
            sat_q    <= sat_d;
            ovr_q    <= ovr_d;
            byte_q   <= byte_d;
        end
    end

    assign o_byte       = byte_q;
    assign o_ready      = (state_q == LOAD);
    assign o_valid      = (state_q == READ);
    assign o_overrun    = ovr_q;
    assign o_recip_data = data_q;
    assign o_recip_abs  = abs_q;

endmodule

// File: tb/tb_recip_byte_shim.sv
// Directed bench for recip_byte_shim with a stub core.
// Stub: result = ~operand, sat = (operand == 0).
module tb_recip_byte_shim;

    logic        clk;
    logic        reset;
    logic [7:0]  i_byte;
    logic        i_wr, i_abs, i_rd;
    logic [7:0]  o_byte;
    logic        o_ready, o_valid, o_overrun;
    logic [23:0] o_recip_data;
    logic        o_recip_abs;
    logic [23:0] i_recip_data;
    logic        i_recip_sat;

    logic [7:0]  b3;
    logic        wr3, abs3, rd3;
    logic [7:0]  o_byte3;
    logic        ready3, valid3, ovr3;
    logic [23:0] data3;
    logic        rabs3;
    logic [23:0] res3;
    logic        sat3;
    logic        force3;
    logic [23:0] force_val;

    int n_chk = 0;
    int n_err = 0;

    assign i_recip_data = ~o_recip_data;
    assign i_recip_sat  = (o_recip_data == 24'h0);
    assign res3 = force3 ? force_val : ~data3;
    assign sat3 = (data3 == 24'h0);

    recip_byte_shim #(.DATA_W(24), .RESULT_WAIT(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_byte       (i_byte),
        .i_wr         (i_wr),
        .i_abs        (i_abs),
        .i_rd         (i_rd),
        .o_byte       (o_byte),
        .o_ready      (o_ready),
        .o_valid      (o_valid),
        .o_overrun    (o_overrun),
        .o_recip_data (o_recip_data),
        .o_recip_abs  (o_recip_abs),
        .i_recip_data (i_recip_data),
        .i_recip_sat  (i_recip_sat)
    );

    recip_byte_shim #(.DATA_W(24), .RESULT_WAIT(3)) dut3 (
        .clk          (clk),
        .reset        (reset),
        .i_byte       (b3),
        .i_wr         (wr3),
        .i_abs        (abs3),
        .i_rd         (rd3),
        .o_byte       (o_byte3),
        .o_ready      (ready3),
        .o_valid      (valid3),
        .o_overrun    (ovr3),
        .o_recip_data (data3),
        .o_recip_abs  (rabs3),
        .i_recip_data (res3),
        .i_recip_sat  (sat3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] b, input logic a);
        i_byte = b;
        i_abs  = a;
        i_wr   = 1'b1;
        @(negedge clk);
        i_wr   = 1'b0;
        i_abs  = 1'b0;
    endtask

    task automatic rd();
        i_rd = 1'b1;
        @(negedge clk);
        i_rd = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        i_byte = 8'h00; i_wr = 1'b0; i_abs = 1'b0; i_rd = 1'b0;
        b3 = 8'h00; wr3 = 1'b0; abs3 = 1'b0; rd3 = 1'b0;
        force3 = 1'b0; force_val = 24'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_byte", 32'(o_byte), 32'h0);
        chk("rst_ovr", 32'(o_overrun), 32'd0);
        chk("rst_data", 32'(o_recip_data), 32'h0);
        chk("rst_abs", 32'(o_recip_abs), 32'd0);

        // Operand 0x123456, abs on the last byte
        wr(8'h12, 1'b0);
        wr(8'h34, 1'b0);
        wr(8'h56, 1'b1);
        chk("t1_data", 32'(o_recip_data), 32'h123456);
        chk("t1_abs", 32'(o_recip_abs), 32'd1);
        chk("t1_ready", 32'(o_ready), 32'd0);
        chk("t1_wait_valid", 32'(o_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid", 32'(o_valid), 32'd1);
        chk("t1_b0", 32'(o_byte), 32'hED);
        rd();
        chk("t1_b1", 32'(o_byte), 32'hCB);
        rd();
        chk("t1_b2", 32'(o_byte), 32'hA9);
        rd();
        chk("t1_stat", 32'(o_byte), 32'h40);
        rd();
        chk("t1_ready_end", 32'(o_ready), 32'd1);
        chk("t1_valid_end", 32'(o_valid), 32'd0);
        chk("t1_byte_end", 32'(o_byte), 32'h0);

        // Zero operand saturates
        wr(8'h00, 1'b0);
        wr(8'h00, 1'b0);
        wr(8'h00, 1'b0);
        @(negedge clk);
        chk("t2_b0", 32'(o_byte), 32'hFF);
        rd();
        chk("t2_b1", 32'(o_byte), 32'hFF);
        rd();
        chk("t2_b2", 32'(o_byte), 32'hFF);
        rd();
        chk("t2_stat", 32'(o_byte), 32'h80);
        rd();
        chk("t2_ovr", 32'(o_overrun), 32'd0);

        // Read in LOAD does nothing
        rd();
        chk("t3_idle_ready", 32'(o_ready), 32'd1);
        chk("t3_idle_byte", 32'(o_byte), 32'h0);

        // Write collides with read in READ
        wr(8'h01, 1'b0);
        wr(8'h02, 1'b0);
        wr(8'h03, 1'b0);
        @(negedge clk);
        chk("t3_b0", 32'(o_byte), 32'hFE);
        i_byte = 8'h99;
        i_wr = 1'b1;
        i_rd = 1'b1;
        @(negedge clk);
        i_wr = 1'b0;
        i_rd = 1'b0;
        chk("t3_b1", 32'(o_byte), 32'hFD);
        chk("t3_ovr", 32'(o_overrun), 32'd1);
        chk("t3_data", 32'(o_recip_data), 32'h010203);
        rd();
        chk("t3_b2", 32'(o_byte), 32'hFC);
        rd();
        chk("t3_stat", 32'(o_byte), 32'h00);
        rd();
        chk("t3_ready", 32'(o_ready), 32'd1);
        chk("t3_ovr_sticky", 32'(o_overrun), 32'd1);

        // Reset mid-load discards partial operand
        wr(8'h11, 1'b0);
        wr(8'h22, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t4_ovr_clr", 32'(o_overrun), 32'd0);
        chk("t4_data_clr", 32'(o_recip_data), 32'h0);
        wr(8'hAA, 1'b0);
        wr(8'hBB, 1'b0);
        wr(8'hCC, 1'b0);
        chk("t4_data", 32'(o_recip_data), 32'hAABBCC);
        @(negedge clk);
        chk("t4_b0", 32'(o_byte), 32'h55);
        repeat (4) rd();
        chk("t4_ready", 32'(o_ready), 32'd1);

        // RESULT_WAIT = 3: capture uses the third WAIT-cycle value
        b3 = 8'h00; wr3 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        b3 = 8'h05;
        @(negedge clk);
        wr3 = 1'b0;
        chk("w3_data", 32'(data3), 32'h000005);
        force3 = 1'b1;
        force_val = 24'h111111;
        @(negedge clk);
        chk("w3_valid1", 32'(valid3), 32'd0);
        force_val = 24'h222222;
        @(negedge clk);
        chk("w3_valid2", 32'(valid3), 32'd0);
        force_val = 24'h333333;
        @(negedge clk);
        force_val = 24'h444444;
        chk("w3_valid3", 32'(valid3), 32'd1);
        chk("w3_b0", 32'(o_byte3), 32'h33);
        rd3 = 1'b1;
        @(negedge clk);
        rd3 = 1'b0;
        chk("w3_b1", 32'(o_byte3), 32'h33);
        chk("w3_ovr", 32'(ovr3), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
